// File: rtl/sine_pair_sweep_ctrl.sv
// Linear frequency-sweep sequencer for the dual-sine summing generator.
// It steps delta_a/delta_b from their start values towards their stop values.
// Each value is held for max(dwell_len,1) cycles. The sweep can loop.

// Per-channel step logic: finished flag and next clamped value
module sine_pair_sweep_lane #(
  parameter int DW = 12
) (
  input  logic [DW-1:0] delta,
  input  logic [DW-1:0] stop,
  input  logic [DW-1:0] step,
  output logic          fin,
  output logic [DW-1:0] nxt
);
  logic [DW:0] sum;

  // Sum is one bit wider so a step near the top of the range clamps instead of wrapping
  always_comb begin
    sum = {1'b0, delta} + {1'b0, step};
    fin = (delta >= stop) || (step == '0);
    if (fin)
      nxt = delta;
    else if (sum >= {1'b0, stop})
      nxt = stop;
    else
      nxt = sum[DW-1:0];
  end
endmodule

module sine_pair_sweep_ctrl #(
  parameter int DW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          loop_en,
  input  logic [DW-1:0] start_a,
  input  logic [DW-1:0] start_b,
  input  logic [DW-1:0] stop_a,
  input  logic [DW-1:0] stop_b,
  input  logic [DW-1:0] step_a,
  input  logic [DW-1:0] step_b,
  input  logic [CW-1:0] dwell_len,
  output logic [DW-1:0] delta_a,
  output logic [DW-1:0] delta_b,
  output logic          busy,
  output logic          step_strobe,
  output logic          done
);
  localparam int NUM_LANES = 2;

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                        state_q, state_d;
  logic [NUM_LANES-1:0][DW-1:0]  delta_q, delta_d;
  logic [NUM_LANES-1:0][DW-1:0]  cfg_start_q, cfg_start_d;
  logic [NUM_LANES-1:0][DW-1:0]  cfg_stop_q, cfg_stop_d;
  logic [NUM_LANES-1:0][DW-1:0]  cfg_step_q, cfg_step_d;
  logic [CW-1:0]                 dwell_m1_q, dwell_m1_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          busy_q, busy_d;
  logic                          strobe_q, strobe_d;
  logic                          done_q, done_d;

  logic [NUM_LANES-1:0][DW-1:0]  start_in, stop_in, step_in, nxt;
  logic [NUM_LANES-1:0]          fin;
  logic [CW-1:0]                 dwell_m1_in;

  assign start_in = {start_b, start_a};
  assign stop_in  = {stop_b, stop_a};
  assign step_in  = {step_b, step_a};

  // A dwell of 0 behaves like 1, so the counter reload never underflows
  assign dwell_m1_in = (dwell_len == '0) ? '0 : dwell_len - CW'(1);

  // The lanes work on the latched configuration, so live cfg inputs cannot disturb a sweep
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sine_pair_sweep_lane #(.DW(DW)) u_lane (
      .delta (delta_q[l]),
      .stop  (cfg_stop_q[l]),
      .step  (cfg_step_q[l]),
      .fin   (fin[l]),
      .nxt   (nxt[l])
    );
  end

  // Next-state logic: abort wins, then start in IDLE, then dwell/step/loop/finish in DWELL
  always_comb begin
    state_d     = state_q;
    delta_d     = delta_q;
    cfg_start_d = cfg_start_q;
    cfg_stop_d  = cfg_stop_q;
    cfg_step_d  = cfg_step_q;
    dwell_m1_d  = dwell_m1_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    strobe_d    = 1'b0;
    done_d      = 1'b0;
    if (abort) begin
      state_d = IDLE;
      delta_d = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_start_d = start_in;
            cfg_stop_d  = stop_in;
            cfg_step_d  = step_in;
            dwell_m1_d  = dwell_m1_in;
            delta_d     = start_in;
            cnt_d       = dwell_m1_in;
            busy_d      = 1'b1;
            state_d     = DWELL;
          end
        end
        DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (!(&fin)) begin
            delta_d  = nxt;
            cnt_d    = dwell_m1_q;
            strobe_d = 1'b1;
          end else if (loop_en) begin
            delta_d  = cfg_start_q;
            cnt_d    = dwell_m1_q;
            strobe_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      delta_q     <= '0;
      cfg_start_q <= '0;
      cfg_stop_q  <= '0;
      cfg_step_q  <= '0;
      dwell_m1_q  <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      delta_q     <= delta_d;
      cfg_start_q <= cfg_start_d;
      cfg_stop_q  <= cfg_stop_d;
      cfg_step_q  <= cfg_step_d;
      dwell_m1_q  <= dwell_m1_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
    end
  end

  assign delta_a     = delta_q[0];
  assign delta_b     = delta_q[1];
  assign busy        = busy_q;
  assign step_strobe = strobe_q;
  assign done        = done_q;
endmodule

// File: tb/tb_sine_pair_sweep_ctrl.sv
// Bench for sine_pair_sweep_ctrl: table of sweep vectors, hand-written corner
// sequences, and randomized sweeps against a value-list model of the sweep.
module tb_sine_pair_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, loop_en;
  logic [11:0] start_a, start_b, stop_a, stop_b, step_a, step_b;
  logic [15:0] dwell_len;
  logic [11:0] delta_a, delta_b;
  logic        busy, step_strobe, done;

  int n_chk  = 0;
  int n_fail = 0;

  sine_pair_sweep_ctrl #(.DW(12), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .start_a(start_a), .start_b(start_b), .stop_a(stop_a), .stop_b(stop_b),
    .step_a(step_a), .step_b(step_b), .dwell_len(dwell_len),
    .delta_a(delta_a), .delta_b(delta_b), .busy(busy),
    .step_strobe(step_strobe), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sa, pa, ta, sb, pb, tb, dw;
    int exp_cycles, exp_strobes, exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock, then settle 1 time unit past the edge before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int sa, input int pa, input int ta,
                         input int sb, input int pb, input int tb, input int dw);
    start_a = 12'(sa); stop_a = 12'(pa); step_a = 12'(ta);
    start_b = 12'(sb); stop_b = 12'(pb); step_b = 12'(tb);
    dwell_len = 16'(dw);
  endtask

  // Runs one sweep and compares the aggregate behaviour with the table row
  task automatic run_vec(input vec_t v, input int idx);
    int cycles, strobes, seen;
    set_cfg(v.sa, v.pa, v.ta, v.sb, v.pb, v.tb, v.dw);
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("vec%0d first_a", idx), delta_a, v.sa);
    chk($sformatf("vec%0d first_b", idx), delta_b, v.sb);
    cycles = 0; strobes = 0; seen = 0;
    while (cycles < 300) begin
      if (done) begin seen = 1; break; end
      if (busy) cycles++;
      if (step_strobe) strobes++;
      step();
    end
    chk($sformatf("vec%0d done_seen", idx), seen, 1);
    chk($sformatf("vec%0d busy_cycles", idx), cycles, v.exp_cycles);
    chk($sformatf("vec%0d strobes", idx), strobes, v.exp_strobes);
    chk($sformatf("vec%0d final_a", idx), delta_a, v.exp_fa);
    chk($sformatf("vec%0d final_b", idx), delta_b, v.exp_fb);
    chk($sformatf("vec%0d busy_at_done", idx), busy, 0);
  endtask

  // Randomized sweep: the model lists the value pairs the sweep must visit, then
  // every cycle is compared. Cfg inputs and start are scrambled while busy.
  task automatic run_rand(input int sa, input int pa, input int ta,
                          input int sb, input int pb, input int tb, input int dw, input int idx);
    int qa[$];
    int qb[$];
    int a, b, d;
    bit fa, fb;
    a = sa; b = sb;
    while (1) begin
      qa.push_back(a); qb.push_back(b);
      fa = (a >= pa) || (ta == 0);
      fb = (b >= pb) || (tb == 0);
      if (fa && fb) break;
      if (!fa) a = (a + ta > pa) ? pa : a + ta;
      if (!fb) b = (b + tb > pb) ? pb : b + tb;
    end
    d = (dw == 0) ? 1 : dw;
    set_cfg(sa, pa, ta, sb, pb, tb, dw);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < qa.size(); i++) begin
      for (int c = 0; c < d; c++) begin
        chk($sformatf("rnd%0d v%0d c%0d delta_a", idx, i, c), delta_a, qa[i]);
        chk($sformatf("rnd%0d v%0d c%0d delta_b", idx, i, c), delta_b, qb[i]);
        chk($sformatf("rnd%0d v%0d c%0d busy", idx, i, c), busy, 1);
        chk($sformatf("rnd%0d v%0d c%0d strobe", idx, i, c), step_strobe, (i > 0 && c == 0) ? 1 : 0);
        chk($sformatf("rnd%0d v%0d c%0d done", idx, i, c), done, 0);
        start = 1'($urandom_range(0, 1));
        set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                $urandom_range(0, 7));
        step();
      end
    end
    start = 1'b0;
    chk($sformatf("rnd%0d done", idx), done, 1);
    chk($sformatf("rnd%0d busy_end", idx), busy, 0);
    chk($sformatf("rnd%0d strobe_end", idx), step_strobe, 0);
    chk($sformatf("rnd%0d final_a", idx), delta_a, qa[qa.size()-1]);
    chk($sformatf("rnd%0d final_b", idx), delta_b, qb[qb.size()-1]);
  endtask

  initial begin
    int sa, pa, ta, sb, pb, tb, dw;

    vecs[0] = '{sa:100,  pa:130,  ta:10,   sb:200,  pb:205,  tb:4, dw:3, exp_cycles:12, exp_strobes:3, exp_fa:130,  exp_fb:205};
    vecs[1] = '{sa:50,   pa:40,   ta:5,    sb:7,    pb:0,    tb:0, dw:0, exp_cycles:1,  exp_strobes:0, exp_fa:50,   exp_fb:7};
    vecs[2] = '{sa:4090, pa:4095, ta:4,    sb:0,    pb:0,    tb:0, dw:2, exp_cycles:6,  exp_strobes:2, exp_fa:4095, exp_fb:0};
    vecs[3] = '{sa:0,    pa:4095, ta:4095, sb:1,    pb:3,    tb:1, dw:1, exp_cycles:3,  exp_strobes:2, exp_fa:4095, exp_fb:3};
    vecs[4] = '{sa:10,   pa:12,   ta:1,    sb:3000, pb:2990, tb:1, dw:5, exp_cycles:15, exp_strobes:2, exp_fa:12,   exp_fb:3000};

    rst = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset delta_a", delta_a, 0);
    chk("reset delta_b", delta_b, 0);
    chk("reset busy", busy, 0);
    chk("reset strobe", step_strobe, 0);
    chk("reset done", done, 0);
    rst = 1'b1;
    step();
    step();
    chk("idle busy", busy, 0);

    // Table vectors run back to back: each start lands in the done cycle of the previous sweep
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    chk("hold after done a", delta_a, 12);
    step();
    chk("done one cycle", done, 0);
    chk("hold in idle a", delta_a, 12);
    chk("hold in idle b", delta_b, 3000);

    // Loop: after the last dwell the sweep restarts with a strobe and no done
    loop_en = 1'b1;
    set_cfg(100, 130, 10, 200, 205, 4, 3);
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c < 13; c++) begin
      chk($sformatf("loop c%0d no_done", c), done, 0);
      step();
    end
    chk("loop restart a", delta_a, 100);
    chk("loop restart b", delta_b, 200);
    chk("loop restart strobe", step_strobe, 1);
    chk("loop restart busy", busy, 1);
    chk("loop restart done", done, 0);
    loop_en = 1'b0;
    repeat (12) step();
    chk("loop exit done", done, 1);
    chk("loop exit a", delta_a, 130);
    chk("loop exit b", delta_b, 205);
    step();

    // Abort mid-dwell while holding 110
    set_cfg(100, 130, 10, 200, 205, 4, 3);
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    chk("pre-abort a", delta_a, 110);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort a", delta_a, 0);
    chk("abort b", delta_b, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort strobe", step_strobe, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("post-abort c%0d done", c), done | step_strobe | busy, 0);
    end

    // start together with abort is ignored
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start+abort busy", busy, 0);
    chk("start+abort a", delta_a, 0);
    step();
    chk("start+abort idle", busy, 0);

    // start while busy with different cfg has no effect
    set_cfg(100, 130, 10, 200, 205, 4, 3);
    start = 1'b1; step(); start = 1'b0;
    set_cfg(999, 1000, 1, 5, 9, 1, 1);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("busy-start a", delta_a, 100);
    step();
    chk("busy-start step a", delta_a, 110);
    chk("busy-start step b", delta_b, 204);
    repeat (9) step();
    chk("busy-start done", done, 1);
    chk("busy-start final a", delta_a, 130);

    // Asynchronous reset between edges mid-sweep
    set_cfg(100, 130, 10, 200, 205, 4, 3);
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    chk("async rst a", delta_a, 0);
    chk("async rst b", delta_b, 0);
    chk("async rst busy", busy, 0);
    #4 rst = 1'b1;
    repeat (3) step();
    chk("post-rst busy", busy, 0);
    chk("post-rst a", delta_a, 0);

    // Randomized sweeps
    for (int r = 0; r < 30; r++) begin
      sa = $urandom_range(0, 4095);
      sb = $urandom_range(0, 4095);
      if ($urandom_range(0, 2) == 0) begin
        pa = (sa + $urandom_range(0, 20) > 4095) ? 4095 : sa + $urandom_range(0, 20);
        ta = $urandom_range(0, 7);
      end else begin
        pa = $urandom_range(0, 4095);
        ta = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(256, 4095);
      end
      pb = $urandom_range(0, 4095);
      tb = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(256, 4095);
      dw = $urandom_range(0, 4);
      run_rand(sa, pa, ta, sb, pb, tb, dw, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end
endmodule
